ins_cache: RTL

- Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory controller.
- Answers fetch lookups combinationally in the same cycle: hit plus instruction word.
- On a miss, fetches the whole line one word at a time from the memory controller, then installs it.
- Line storage is register-based, so lookups have zero latency.

---
 rtl/ins_cache_pkg.sv | 20 ++
 rtl/ins_cache_array.sv | 47 ++++
 rtl/ins_cache.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ins_cache_pkg.sv
// rtl/ins_cache_pkg.sv - shared instruction-cache constants, slice widths and FSM encoding
package ins_cache_pkg;

  localparam int XLEN         = 32;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_OFS_W = 4;
  localparam int ICACHE_TAG_W = XLEN - ICACHE_IDX_W - ICACHE_OFS_W;
  localparam int ICACHE_WORDS = 2 ** (ICACHE_OFS_W - 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    WRITE = ST_WRITE
  } icache_state_e;

endpackage

// File: rtl/ins_cache_array.sv
// rtl/ins_cache_array.sv - direct-mapped tag/valid/data storage, one combinational read port, one line-write port
module ins_cache_array
  import ins_cache_pkg::*;
#(
  parameter int IDX_W  = ICACHE_IDX_W,
  parameter int TAG_W  = ICACHE_TAG_W,
  parameter int WORD_W = ICACHE_OFS_W - 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IDX_W-1:0]                 rd_idx,
  input  logic [TAG_W-1:0]                 rd_tag,
  input  logic [WORD_W-1:0]                rd_word,
  output logic                             rd_hit,
  output logic [XLEN-1:0]                  rd_data,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [TAG_W-1:0]                 wr_tag,
  input  logic [2**WORD_W-1:0][XLEN-1:0]   wr_line
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0]                 valid_q;
  logic [TAG_W-1:0]                 tag_q  [LINES];
  logic [2**WORD_W-1:0][XLEN-1:0]   data_q [LINES];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx][rd_word];

endmodule

// File: rtl/ins_cache.sv
// rtl/ins_cache.sv - direct-mapped read-only instruction cache with word-serial line fill
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module ins_cache
  import ins_cache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int OFS_W = ICACHE_OFS_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            hit,
  output logic [XLEN-1:0] ins,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
`endif
);

  localparam int TAG_W  = XLEN - IDX_W - OFS_W;
  localparam int WORD_W = OFS_W - 2;
  localparam int LINE_W = XLEN - OFS_W;
  localparam logic [WORD_W-1:0] CNT_LAST = '1;

  icache_state_e                  state_q, state_d;
  logic [WORD_W-1:0]              cnt_q;
  logic [LINE_W-1:0]              miss_line_q;
  logic [2**WORD_W-1:0][XLEN-1:0] line_buf_q;
  logic                           arr_hit;
  logic [XLEN-1:0]                arr_data;
  logic                           miss_start;
  logic                           fill_take;
  logic                           wr_en;

  ins_cache_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (fetch_addr[IDX_W+OFS_W-1:OFS_W]),
    .rd_tag  (fetch_addr[XLEN-1:IDX_W+OFS_W]),
    .rd_word (fetch_addr[OFS_W-1:2]),
    .rd_hit  (arr_hit),
    .rd_data (arr_data),
    .wr_en   (wr_en),
    .wr_idx  (miss_line_q[IDX_W-1:0]),
    .wr_tag  (miss_line_q[LINE_W-1:IDX_W]),
    .wr_line (line_buf_q)
  );

  assign hit = arr_hit;
  assign ins = arr_hit ? arr_data : '0;

  // Every transition and array write is qualified by rdy so a stall freezes the whole block.
  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    fill_take  = 1'b0;
    wr_en      = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!arr_hit) begin
            miss_start = 1'b1;
            state_d    = FILL;
          end
        end
        FILL: begin
          if (mem_done) begin
            fill_take = 1'b1;
            if (cnt_q == CNT_LAST) state_d = WRITE;
          end
        end
        WRITE: begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A redirect of fetch_addr mid-fill is ignored; the original line always completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cnt_q       <= '0;
      miss_line_q <= '0;
    end else if (miss_start) begin
      miss_line_q <= fetch_addr[XLEN-1:OFS_W];
      mem_req     <= 1'b1;
      mem_addr    <= {fetch_addr[XLEN-1:OFS_W], {OFS_W{1'b0}}};
      cnt_q       <= '0;
    end else if (fill_take) begin
      if (cnt_q != CNT_LAST) begin
        cnt_q    <= cnt_q + WORD_W'(1);
        mem_addr <= mem_addr + XLEN'(4);
      end else begin
        mem_req  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_take) line_buf_q[cnt_q] <= mem_data;
  end

`ifdef ICACHE_STATS_EN
  logic [XLEN-1:0] prev_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_addr_q <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else if (rdy) begin
      prev_addr_q <= fetch_addr;
      if (arr_hit && (fetch_addr != prev_addr_q)) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^fetch_addr[1:0];
`endif

endmodule
